// File: rtl/c3lib_pkg.sv
// c3lib_pkg: shared state encoding and counter-width helper for the c3lib strap reader.
package c3lib_pkg;

    typedef enum logic [1:0] {SETTLE, SAMPLE1, SAMPLE2, DONE} c3lib_strap_state_e;

    // A counter that reaches n-1 needs $clog2(n) bits, but never fewer than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/c3lib_strap_settle_cnt.sv
// c3lib_strap_settle_cnt: up-counter with clear, saturating at MAX-1 and flagging it on tc.
module c3lib_strap_settle_cnt
    import c3lib_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int W = cnt_w(MAX);
    localparam logic [W-1:0] TC_VAL = W'(MAX - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (inc && !tc)
            r_cnt <= r_cnt + 1'b1;
    end

    assign tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/c3lib_mtie_strap_capture.sv
// c3lib_mtie_strap_capture: settles, double-samples and holds mtie strap values,
// with software override and an acknowledged recapture handshake.
module c3lib_mtie_strap_capture
    import c3lib_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               SETTLE_CYCLES = 4,
    parameter int               MAX_RETRY     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] strap_in,
    input  logic             recapture_req,
    input  logic             ovrd_en,
    input  logic [WIDTH-1:0] ovrd_val,
    output logic [WIDTH-1:0] strap_out,
    output logic             strap_valid,
    output logic             recapture_ack,
    output logic             strap_err
);

    c3lib_strap_state_e r_state, w_next;
    logic [WIDTH-1:0]   r_sample_a, r_cap_q;
    logic               r_pending;
    logic               w_settle_inc, w_settle_clr, w_settle_tc;
    logic               w_retry_inc, w_retry_clr, w_retry_tc;
    logic               w_sample, w_capture, w_force, w_req;

    c3lib_strap_settle_cnt #(.MAX(SETTLE_CYCLES)) u_settle_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_settle_clr),
        .inc  (w_settle_inc),
        .tc   (w_settle_tc)
    );

    c3lib_strap_settle_cnt #(.MAX(MAX_RETRY)) u_retry_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_retry_clr),
        .inc  (w_retry_inc),
        .tc   (w_retry_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= SETTLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_settle_inc = 1'b0;
        w_settle_clr = 1'b0;
        w_retry_inc  = 1'b0;
        w_retry_clr  = 1'b0;
        w_sample     = 1'b0;
        w_capture    = 1'b0;
        w_force      = 1'b0;
        w_req        = 1'b0;
        case (r_state)
            SETTLE: begin
                w_settle_inc = 1'b1;
                w_settle_clr = w_settle_tc;
                w_next       = w_settle_tc ? SAMPLE1 : SETTLE;
            end
            SAMPLE1: begin
                w_sample = 1'b1;
                w_next   = SAMPLE2;
            end
            SAMPLE2: begin
                // A mismatch on the last allowed attempt still captures, but flags the error.
                w_force     = (strap_in != r_sample_a) && w_retry_tc;
                w_capture   = (strap_in == r_sample_a) || w_retry_tc;
                w_retry_clr = w_capture;
                w_retry_inc = !w_capture;
                w_next      = w_capture ? DONE : SETTLE;
            end
            DONE: begin
                w_req  = recapture_req;
                w_next = recapture_req ? SETTLE : DONE;
            end
            default: w_next = SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_a    <= '0;
            r_cap_q       <= RESET_VAL;
            r_pending     <= 1'b0;
            strap_out     <= RESET_VAL;
            strap_valid   <= 1'b0;
            recapture_ack <= 1'b0;
            strap_err     <= 1'b0;
        end else begin
            r_sample_a    <= w_sample ? strap_in : r_sample_a;
            r_cap_q       <= w_capture ? strap_in : r_cap_q;
            r_pending     <= w_req ? 1'b1 : (w_capture ? 1'b0 : r_pending);
            strap_out     <= ovrd_en ? ovrd_val : (w_capture ? strap_in : r_cap_q);
            strap_valid   <= strap_valid | w_capture;
            recapture_ack <= w_capture & r_pending;
            strap_err     <= strap_err | w_force;
        end
    end

endmodule
